// File: rtl/ntt_stage_ctrl_if.sv
// Coefficient-RAM / twiddle-ROM bus driven by the NTT stage controller.
interface ntt_stage_ctrl_if #(
  parameter int LOG_N = 7
);
  logic             rd_en;
  logic [LOG_N-1:0] rd_addr_a;
  logic [LOG_N-1:0] rd_addr_b;
  logic [LOG_N-2:0] tw_idx;
  logic             wr_en;
  logic [LOG_N-1:0] wr_addr_a;
  logic [LOG_N-1:0] wr_addr_b;

  modport master (
    output rd_en, rd_addr_a, rd_addr_b, tw_idx,
    output wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input rd_en, rd_addr_a, rd_addr_b, tw_idx,
    input wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_stage_ctrl.sv
// Sequencer for an in-place iterative Cooley-Tukey NTT over one shared butterfly.
// Define NTT_STALL_EN to add a stall input that pauses issue during RUN.
module ntt_stage_ctrl #(
  parameter int LOG_N    = 7,
  parameter int BFLY_LAT = 6,
  parameter int STG_W    = 3
) (
  input  logic             clk_100Mhz,
  input  logic             rst_n,
  input  logic             start,
`ifdef NTT_STALL_EN
  input  logic             stall,
`endif
  output logic             busy,
  output logic             done,
  output logic [STG_W-1:0] stage,
  ntt_stage_ctrl_if.master mem
);
  localparam int JW  = LOG_N - 1;
  localparam int DW  = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam int DLW = 1 + 2 * LOG_N;
  localparam logic [JW-1:0]    J_LAST   = '1;
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(LOG_N - 1);
  localparam logic [DW-1:0]    DRN_LAST = DW'(BFLY_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [JW-1:0]    j_reg, j_next;
  logic [STG_W-1:0] stage_reg, stage_next;
  logic [DW-1:0]    drn_reg, drn_next;
  logic             hold;
  logic             issue;
  logic [LOG_N-1:0] j_ext, half, mask, k, addr_a, tw_full;
  logic [DLW-1:0]   dly_reg [BFLY_LAT];

`ifdef NTT_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      j_reg     <= '0;
      stage_reg <= '0;
      drn_reg   <= '0;
    end else begin
      state_reg <= state_next;
      j_reg     <= j_next;
      stage_reg <= stage_next;
      drn_reg   <= drn_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    j_next     = j_reg;
    stage_next = stage_reg;
    drn_next   = drn_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
          j_next     = '0;
          stage_next = '0;
        end
      end
      S_RUN: begin
        if (!hold) begin
          j_next = j_reg + JW'(1);
          if (j_reg == J_LAST) begin
            state_next = S_DRAIN;
            drn_next   = '0;
          end
        end
      end
      S_DRAIN: begin
        // The last write of the stage retires in this final drain cycle.
        if (drn_reg == DRN_LAST) begin
          if (stage_reg == STG_LAST) begin
            state_next = S_DONE;
          end else begin
            state_next = S_RUN;
            stage_next = stage_reg + STG_W'(1);
            j_next     = '0;
          end
        end else begin
          drn_next = drn_reg + DW'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        stage_next = '0;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Butterfly j of stage s: group bits move up one place, low stage bits stay as k.
  always_comb begin
    j_ext   = {1'b0, j_reg};
    half    = LOG_N'(1) << stage_reg;
    mask    = half - LOG_N'(1);
    k       = j_ext & mask;
    addr_a  = ((j_ext & ~mask) << 1) | k;
    tw_full = k << (STG_LAST - stage_reg);
  end

  always_comb begin
    issue = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_reg)
      S_RUN: begin
        busy  = 1'b1;
        issue = !hold;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    mem.rd_en     = issue;
    mem.rd_addr_a = issue ? addr_a : '0;
    mem.rd_addr_b = issue ? addr_a + half : '0;
    mem.tw_idx    = issue ? tw_full[LOG_N-2:0] : '0;
  end

  assign stage = stage_reg;

  // Delay line mirrors the butterfly pipeline, which never stalls.
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BFLY_LAT; i++) dly_reg[i] <= '0;
    end else begin
      dly_reg[0] <= {mem.rd_en, mem.rd_addr_a, mem.rd_addr_b};
      for (int i = 1; i < BFLY_LAT; i++) dly_reg[i] <= dly_reg[i-1];
    end
  end

  assign mem.wr_en     = dly_reg[BFLY_LAT-1][DLW-1];
  assign mem.wr_addr_a = dly_reg[BFLY_LAT-1][2*LOG_N-1:LOG_N];
  assign mem.wr_addr_b = dly_reg[BFLY_LAT-1][LOG_N-1:0];
endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Scoreboard bench for ntt_stage_ctrl: small 8-point instance plus a default-size instance.
`timescale 1ns/1ps
module tb_ntt_stage_ctrl;
  localparam int LN      = 3;
  localparam int LAT     = 6;
  localparam int SW      = 2;
  localparam int NP      = 8;
  localparam int RUN_CYC = LN * (NP / 2 + LAT) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, start2;
  logic          busy, done, busy2, done2;
  logic [SW-1:0] stage;
  logic [2:0]    stage2;
`ifdef NTT_STALL_EN
  logic          stall, stall2;
`endif

  ntt_stage_ctrl_if #(.LOG_N(LN)) m_if ();
  ntt_stage_ctrl_if #(.LOG_N(7))  b_if ();

  ntt_stage_ctrl #(.LOG_N(LN), .BFLY_LAT(LAT), .STG_W(SW)) dut (
    .clk_100Mhz(clk),
    .rst_n(rst_n),
    .start(start),
`ifdef NTT_STALL_EN
    .stall(stall),
`endif
    .busy(busy),
    .done(done),
    .stage(stage),
    .mem(m_if.master)
  );

  ntt_stage_ctrl dut_big (
    .clk_100Mhz(clk),
    .rst_n(rst_n),
    .start(start2),
`ifdef NTT_STALL_EN
    .stall(stall2),
`endif
    .busy(busy2),
    .done(done2),
    .stage(stage2),
    .mem(b_if.master)
  );

  typedef struct {
    int stg;
    int a;
    int b;
    int tw;
  } op_t;

  op_t rd_q[$];
  op_t wr_q[$];
  int  done_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: every stage walks groups of 2*half points, pairing k with k+half.
  task automatic push_model();
    for (int s = 0; s < LN; s++) begin
      int half;
      half = 2 ** s;
      for (int base = 0; base < NP; base += 2 * half) begin
        for (int k = 0; k < half; k++) begin
          op_t o;
          o.stg = s;
          o.a   = base + k;
          o.b   = base + k + half;
          o.tw  = k * ((NP / 2) / half);
          rd_q.push_back(o);
          wr_q.push_back(o);
        end
      end
    end
  endtask

  // Monitor: samples on the falling edge and retires expected events in order.
  logic hist_en [8];
  int   hist_a  [8];
  int   hist_b  [8];

  initial begin : monitor
    op_t e;
    int  h;
    for (int i = 0; i < 8; i++) begin
      hist_en[i] = 1'b0;
      hist_a[i]  = 0;
      hist_b[i]  = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      hist_en[cyc & 7] = m_if.rd_en;
      hist_a[cyc & 7]  = int'(m_if.rd_addr_a);
      hist_b[cyc & 7]  = int'(m_if.rd_addr_b);
      if (!rst_n) begin
        chk("rst_rd_en", int'(m_if.rd_en), 0);
        chk("rst_wr_en", int'(m_if.wr_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_addr", int'(m_if.rd_addr_a) + int'(m_if.rd_addr_b), 0);
      end else begin
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", int'(m_if.rd_en), 0);
        end else if (m_if.rd_en) begin
          e = rd_q.pop_front();
          chk("rd_addr_a", int'(m_if.rd_addr_a), e.a);
          chk("rd_addr_b", int'(m_if.rd_addr_b), e.b);
          chk("tw_idx", int'(m_if.tw_idx), e.tw);
          chk("stage", int'(stage), e.stg);
          chk("busy_on_rd", int'(busy), 1);
        end
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", int'(m_if.wr_en), 0);
        end else if (m_if.wr_en) begin
          e = wr_q.pop_front();
          h = (cyc - LAT) & 7;
          chk("wr_addr_a", int'(m_if.wr_addr_a), e.a);
          chk("wr_addr_b", int'(m_if.wr_addr_b), e.b);
          chk("lat_rd_en", int'(hist_en[h]), 1);
          chk("lat_addr_a", int'(m_if.wr_addr_a), hist_a[h]);
          chk("lat_addr_b", int'(m_if.wr_addr_b), hist_b[h]);
        end
        if (done_q.size() == 0) begin
          chk("done_unexpected", int'(done), 0);
        end else if (done) begin
          chk("done_cycle", cyc, done_q.pop_front());
          chk("busy_at_done", int'(busy), 0);
          chk("wr_left_at_done", wr_q.size(), 0);
        end
      end
    end
  end

  // spur: 0 none, 1 start at cycles 5 and 15, 2 random starts while busy.
  task automatic do_run(input int spur, input int rst_at, input int stall_at);
    int nst;
    nst = (stall_at > 0) ? 3 : 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    push_model();
    done_q.push_back(cyc + 1 + RUN_CYC + nst);
    for (int r = 1; r <= RUN_CYC + nst + 2; r++) begin
      @(posedge clk);
      #1;
      start = (spur == 1 && (r == 5 || r == 15)) ||
              (spur == 2 && r <= 30 && $urandom_range(0, 5) == 0);
`ifdef NTT_STALL_EN
      stall = (stall_at > 0 && r >= stall_at && r < stall_at + 3);
`endif
      if (r == 1) chk("busy_after_start", int'(busy), 1);
      if (r == rst_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        #1;
        chk("async_rst_rd_en", int'(m_if.rd_en), 0);
        chk("async_rst_wr_en", int'(m_if.wr_en), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_stage", int'(stage), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        return;
      end
    end
    start = 1'b0;
`ifdef NTT_STALL_EN
    stall = 1'b0;
`endif
    chk("busy_after_done", int'(busy), 0);
    chk("rd_left", rd_q.size(), 0);
    chk("done_left", done_q.size(), 0);
  endtask

  initial begin : stimulus
    int wr2, rd2, dcyc;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
`ifdef NTT_STALL_EN
    stall  = 1'b0;
    stall2 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_stage", int'(stage), 0);

    do_run(0, 0, 0);
    do_run(1, 0, 0);
    do_run(0, 12, 0);
    do_run(0, 0, 0);
`ifdef NTT_STALL_EN
    do_run(0, 0, 3);
`endif
    repeat (6) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      do_run(2, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0, 0);
    end

    // Default-size transform: 7 stages of 64 issues plus 6 drain cycles.
    wr2  = 0;
    rd2  = 0;
    dcyc = -1;
    @(posedge clk);
    #1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      wr2 += int'(b_if.wr_en);
      rd2 += int'(b_if.rd_en);
      if (done2) begin
        dcyc = c;
        break;
      end
    end
    chk("big_done_cycle", dcyc, 491);
    chk("big_wr_count", wr2, 448);
    chk("big_rd_count", rd2, 448);
    @(posedge clk);
    #1;
    chk("big_busy_after", int'(busy2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ntt_stage_ctrl.md
Name: ntt_stage_ctrl

Overview:
- Sequences one shared 2x2 NTT butterfly (multiply, add, Barrett reduce) over a full in-place N-point iterative Cooley-Tukey NTT, N = 2^LOG_N.
- Issues a coefficient-RAM read address pair plus a twiddle index each cycle.
- Tracks the butterfly's fixed pipeline latency and generates the matching write-back addresses.
- Drains the pipeline between stages so that no stage reads data the previous stage has not yet written.

Parameters:
- LOG_N, 7, log2 of transform size; N = 128 points, 64 butterflies per stage.
- BFLY_LAT, 6, cycles from the butterfly accepting operands to its reduced outputs being valid; must be at least 1.
- STG_W, 3, width of the stage index; must satisfy 2^STG_W >= LOG_N.

Ports:
- clk_100Mhz  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to run a full transform; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the final DRAIN cycle.
- done  out  1  one-cycle pulse once the last write of the last stage has retired.
- stage  out  STG_W  current stage index, 0..LOG_N-1.
- rd_en  out  1  read strobe to the coefficient RAM and valid strobe into the butterfly.
- rd_addr_a  out  LOG_N  address of the even operand fi_0.
- rd_addr_b  out  LOG_N  address of the odd operand fi_1.
- tw_idx  out  LOG_N-1  twiddle ROM index for this butterfly.
- wr_en  out  1  write strobe for the butterfly outputs Fi_0 and Fi_1.
- wr_addr_a  out  LOG_N  write address for Fi_0.
- wr_addr_b  out  LOG_N  write address for Fi_1.

Behaviour:
- Reset (asynchronous, at any time including mid-transform):
  - State goes to IDLE.
  - All outputs go to 0 and all counters clear.
  - The delay line is flushed, so no write is emitted after reset.
- FSM states are IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 moves to RUN with stage=0 and j=0. start in any other state is ignored.
- RUN: one butterfly is issued per cycle.
  - rd_en=1.
  - half = 2^stage, g = j>>stage, k = j & (half-1).
  - rd_addr_a = g*2*half + k, computed as a shift, no multiplier.
  - rd_addr_b = rd_addr_a + half.
  - tw_idx = k << (LOG_N-1-stage).
  - j increments each cycle. After issuing j = N/2-1, move to DRAIN with the drain counter at 0.
- DRAIN:
  - rd_en=0.
  - Lasts exactly BFLY_LAT cycles.
  - On the last DRAIN cycle: if stage = LOG_N-1, move to DONE; otherwise increment stage, clear j, and return to RUN.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Write path:
  - A shift register BFLY_LAT deep carries {valid, addr_a, addr_b}.
  - wr_en, wr_addr_a and wr_addr_b equal rd_en, rd_addr_a and rd_addr_b delayed by exactly BFLY_LAT cycles.
  - The delay line shifts every cycle regardless of state, because the butterfly pipeline has no stall.
  - The last write of each stage lands in the final DRAIN cycle, so the next RUN cycle's read sees the updated data.
- Timing:
  - Each stage takes N/2 + BFLY_LAT cycles.
  - With start accepted at cycle 0, done is high at cycle LOG_N*(N/2+BFLY_LAT)+1. For the defaults this is cycle 491.
- Address widths wrap naturally. rd_addr_b never exceeds N-1 by construction, and no overflow checking is required.

Optional Feature:
- Macro: NTT_STALL_EN.
- Defined: adds input port stall (1 bit), which is meaningful only in RUN.
  - While stall=1: rd_en=0, and j, stage and the FSM hold.
  - The delay line keeps shifting, so in-flight writes still retire.
  - The DRAIN length is unaffected.
  - Each stall cycle extends the total by one cycle.
- Not defined: no stall port; RUN issues unconditionally every cycle.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles, then release with start=0 for 20 cycles -> all outputs stay 0 and no wr_en.
- Address sequence (LOG_N=3, BFLY_LAT=6):
  - Stage 0 reads pairs (0,1),(2,3),(4,5),(6,7) with tw 0,0,0,0.
  - Stage 1 reads (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2.
  - Stage 2 reads (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3.
  - done at cycle 31.
- Latency alignment: every wr_en=1 cycle has wr_addr_a/b equal to rd_addr_a/b exactly 6 cycles earlier. Total wr_en count is 12 (LOG_N=3) or 448 (defaults).
- Reset mid-operation: assert rst_n=0 during stage 1 RUN -> outputs immediately 0 and no stale wr_en after release. A following start produces the full correct sequence from stage 0.
- start while busy: pulse start at cycles 5 and 15 of a run -> ignored, single done pulse, cycle count unchanged.
- NTT_STALL_EN defined: assert stall for 3 cycles at j=2 of stage 0 -> rd_en gaps of 3 cycles, sequence unchanged, and done delayed by exactly 3 cycles.
